mem_responder: RTL and testbench

//  Memory-side responder for the core's request/valid memory port: the other end of the fetch/LSU

---
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency request/valid responder over a word-addressed byte-masked RAM.
// Optional MEM_MISALIGN_CHECK_EN adds an err port flagging transactions with address[1:0] != 0.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        busy
`ifdef MEM_MISALIGN_CHECK_EN
   ,output logic        err
`endif
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] a_q, a_s;
    logic [3:0]    m_q, m_s;
    logic          we_q, we_s;
    logic [31:0]   wd_q, wd_s, lane;
    logic          go_resp, bad;
    logic [31:0]   mem [DEPTH];
`ifdef MEM_MISALIGN_CHECK_EN
    logic          mis_q;
`endif
    // In IDLE the live inputs drive the access so LATENCY=1 can respond on the accept edge.
    always_comb begin
        a_s     = state == IDLE ? address[AW+1:2] : a_q;
        m_s     = state == IDLE ? mask : m_q;
        we_s    = state == IDLE ? we_re : we_q;
        wd_s    = state == IDLE ? wdata : wd_q;
        go_resp = (state == IDLE && request && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
        lane    = {{8{m_s[3]}}, {8{m_s[2]}}, {8{m_s[1]}}, {8{m_s[0]}}};
`ifdef MEM_MISALIGN_CHECK_EN
        bad     = state == IDLE ? |address[1:0] : mis_q;
`else
        bad     = 1'b0;
`endif
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst && go_resp && we_s && !bad)
            for (int i = 0; i < 4; i++)
                if (m_s[i]) mem[a_s][8*i +: 8] <= wd_s[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            rdata <= '0;
            a_q   <= '0;
            m_q   <= '0;
            we_q  <= 1'b0;
            wd_q  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q <= 1'b0;
            err   <= 1'b0;
`endif
        end else begin
            valid <= go_resp;
`ifdef MEM_MISALIGN_CHECK_EN
            err   <= go_resp && bad;
`endif
            if (go_resp) rdata <= (we_s || bad) ? 32'h0 : mem[a_s] & lane;
            case (state)
                IDLE: if (request) begin
                    a_q   <= address[AW+1:2];
                    m_q   <= mask;
                    we_q  <= we_re;
                    wd_q  <= wdata;
`ifdef MEM_MISALIGN_CHECK_EN
                    mis_q <= |address[1:0];
`endif
                    cnt   <= 4'(LATENCY - 1);
                    state <= LATENCY > 1 ? WAIT : RESP;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus hand sequences for back-to-back, reset abort and misalignment.
module tb_mem_responder;
    logic        clk = 0, rst = 0, request = 0, we_re = 0;
    logic [3:0]  mask = 0;
    logic [31:0] address = 0, wdata = 0, rdata;
    logic        valid, busy;
    int          n_chk = 0, n_bad = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        err;
`endif

    mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .wdata(wdata), .rdata(rdata), .valid(valid), .busy(busy)
`ifdef MEM_MISALIGN_CHECK_EN
       ,.err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t v[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input string nm, input logic w, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e, input logic e_err);
        int cyc = 0, nbusy = 0;
        @(negedge clk);
        we_re = w; mask = m; address = a; wdata = d; request = 1;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
        end while (!valid && cyc < 20);
        request = 0;
        chk({nm, "_latency"}, 32'(cyc), 32'd2);
        chk({nm, "_busy"}, 32'(nbusy), 32'd2);
        chk({nm, "_rdata"}, rdata, e);
`ifdef MEM_MISALIGN_CHECK_EN
        chk({nm, "_err"}, {31'b0, err}, {31'b0, e_err});
`else
        if (e_err) chk({nm, "_err_unexpected"}, 32'd1, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, last;
        v[0]  = '{1'b1, 4'b1111, 32'h10,   32'hDEADBEEF, 32'h0};
        v[1]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        32'hDEADBEEF};
        v[2]  = '{1'b1, 4'b0101, 32'h10,   32'h11223344, 32'h0};
        v[3]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        32'hDE22BE44};
        v[4]  = '{1'b0, 4'b0011, 32'h10,   32'h0,        32'h0000BE44};
        v[5]  = '{1'b1, 4'b1111, 32'h1000, 32'hA5A5A5A5, 32'h0};
        v[6]  = '{1'b0, 4'b1111, 32'h0,    32'h0,        32'hA5A5A5A5};
        v[7]  = '{1'b1, 4'b0000, 32'h0,    32'h0,        32'h0};
        v[8]  = '{1'b0, 4'b1111, 32'h0,    32'h0,        32'hA5A5A5A5};
        v[9]  = '{1'b1, 4'b1111, 32'h20,   32'h12345678, 32'h0};
        v[10] = '{1'b0, 4'b1100, 32'h20,   32'h0,        32'h12340000};
        v[11] = '{1'b1, 4'b1111, 32'h4,    32'hCAFEF00D, 32'h0};
        v[12] = '{1'b0, 4'b1010, 32'h4,    32'h0,        32'hCA00F000};

        repeat (2) @(negedge clk);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1;

        for (int i = 0; i < 13; i++)
            txn($sformatf("vec%0d", i), v[i].w, v[i].m, v[i].a, v[i].d, v[i].e, 1'b0);

        // Held request: one valid every 3 cycles, address alternates 0x0 / 0x4.
        @(negedge clk);
        we_re = 0; mask = 4'b1111; address = 32'h0; request = 1;
        nv = 0; last = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (valid) begin
                if (last >= 0) chk("b2b_gap", 32'(i - last), 32'd3);
                chk("b2b_rdata", rdata, address == 32'h0 ? 32'hA5A5A5A5 : 32'hCAFEF00D);
                address = address ^ 32'h4;
                last = i;
                nv++;
            end
            if (i == 12) request = 0;
        end
        chk("b2b_count", 32'(nv), 32'd4);
        @(negedge clk);
        chk("b2b_idle_busy", {31'b0, busy}, 32'h0);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        we_re = 1; mask = 4'b1111; address = 32'h20; wdata = 32'hFFFFFFFF; request = 1;
        @(negedge clk);
        chk("abort_busy_wait", {31'b0, busy}, 32'h1);
        rst = 0; request = 0;
        #1 chk("abort_busy_async", {31'b0, busy}, 32'h0);
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);
        rst = 1;
        txn("abort_read", 1'b0, 4'b1111, 32'h20, 32'h0, 32'h12345678, 1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
        txn("mis_write", 1'b1, 4'b1111, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("mis_read", 1'b0, 4'b1111, 32'h20, 32'h0, 32'h12345678, 1'b0);
`else
        txn("mis_write", 1'b1, 4'b1111, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b0);
        txn("mis_read", 1'b0, 4'b1111, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
